sa_00: RTL

SA_00 -- requirements
Module: sa_00

---
 rtl/sa_00_if.sv | 38 +++
 rtl/sa_00.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sa_00_if.sv
// Switch-allocator port bundle: three requester inputs (E,S,L) and three output ports (E,S,L).
// The slave modport is the allocator's view; master is the surrounding router/testbench.
interface sa_00_if #(
  parameter int DATASIZE = 40
);
  logic [DATASIZE-1:0] E_data_in, S_data_in, L_data_in;
  logic [3:0]          E_direction_in, S_direction_in, L_direction_in;
  logic                E_valid_in, S_valid_in, L_valid_in;
  logic                E_grant, S_grant, L_grant;

  logic [DATASIZE-1:0] E_data_out, S_data_out, L_data_out;
  logic                E_valid_out, S_valid_out, L_valid_out;
  logic                E_ready_in, S_ready_in, L_ready_in;

  logic                err_drop;

  modport slave (
    input  E_data_in, S_data_in, L_data_in,
    input  E_direction_in, S_direction_in, L_direction_in,
    input  E_valid_in, S_valid_in, L_valid_in,
    output E_grant, S_grant, L_grant,
    output E_data_out, S_data_out, L_data_out,
    output E_valid_out, S_valid_out, L_valid_out,
    input  E_ready_in, S_ready_in, L_ready_in,
    output err_drop
  );

  modport master (
    output E_data_in, S_data_in, L_data_in,
    output E_direction_in, S_direction_in, L_direction_in,
    output E_valid_in, S_valid_in, L_valid_in,
    input  E_grant, S_grant, L_grant,
    input  E_data_out, S_data_out, L_data_out,
    input  E_valid_out, S_valid_out, L_valid_out,
    output E_ready_in, S_ready_in, L_ready_in,
    input  err_drop
  );
endinterface

// File: rtl/sa_00.sv
// Wormhole switch allocator: 3 requesters x 3 output registers with per-port locking.
// Define SA_ROUND_ROBIN_EN for per-port round-robin arbitration; otherwise fixed priority E > S > L.
module sa_00 #(
  parameter int DATASIZE = 40
) (
  input  logic   rc_clk,
  input  logic   rst_n,
  sa_00_if.slave bus
);
  localparam int unsigned NP = 3;

  typedef enum logic {OPEN, LOCKED} lock_t;
  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } ftype_t;

  logic [DATASIZE-1:0] din [NP];
  logic [3:0]          dir [NP];
  logic [NP-1:0]       vin;
  logic [NP-1:0]       rdy;
  logic [NP-1:0]       gnt;

  logic [DATASIZE-1:0] dout_q  [NP];
  logic [NP-1:0]       vout_q;
  lock_t               lock_q  [NP];
  lock_t               lock_d  [NP];
  logic [1:0]          owner_q [NP];
  logic [1:0]          owner_d [NP];
  logic                err_q;

  logic [1:0]          tgt      [NP];
  logic [NP-1:0]       legal;
  logic [NP-1:0]       illegal;
  logic [NP-1:0]       port_free;
  logic [NP-1:0]       elig     [NP];
  logic [1:0]          base     [NP];
  logic [NP-1:0]       win_vld;
  logic [1:0]          win_id   [NP];
  logic [DATASIZE-1:0] win_data [NP];
  ftype_t              win_type [NP];
  logic                unused_dir3;

  assign din[0] = bus.E_data_in;
  assign din[1] = bus.S_data_in;
  assign din[2] = bus.L_data_in;
  assign dir[0] = bus.E_direction_in;
  assign dir[1] = bus.S_direction_in;
  assign dir[2] = bus.L_direction_in;
  assign vin    = {bus.L_valid_in, bus.S_valid_in, bus.E_valid_in};
  assign rdy    = {bus.L_ready_in, bus.S_ready_in, bus.E_ready_in};

  assign bus.E_grant     = gnt[0];
  assign bus.S_grant     = gnt[1];
  assign bus.L_grant     = gnt[2];
  assign bus.E_data_out  = dout_q[0];
  assign bus.S_data_out  = dout_q[1];
  assign bus.L_data_out  = dout_q[2];
  assign bus.E_valid_out = vout_q[0];
  assign bus.S_valid_out = vout_q[1];
  assign bus.L_valid_out = vout_q[2];
  assign bus.err_drop    = err_q;

  assign unused_dir3 = dir[0][3] ^ dir[1][3] ^ dir[2][3];

  // Position of 'to' in the search order starting at 'from' (0 = searched first).
  function automatic logic [1:0] rr_dist(input logic [1:0] from, input logic [1:0] to);
    logic [2:0] d;
    d = {1'b0, to} + 3'd3 - {1'b0, from};
    return (d >= 3'd3) ? 2'(d - 3'd3) : d[1:0];
  endfunction

  // Route decode: lowest set direction bit wins; no bit set or an E/S U-turn is dropped.
  always_comb begin
    for (int unsigned r = 0; r < NP; r++) begin
      tgt[r] = '0;
      if      (dir[r][0]) tgt[r] = 2'd0;
      else if (dir[r][1]) tgt[r] = 2'd1;
      else if (dir[r][2]) tgt[r] = 2'd2;
      legal[r]   = vin[r] && (dir[r][2:0] != 3'b000) && !((r != 2) && (tgt[r] == 2'(r)));
      illegal[r] = vin[r] && !legal[r];
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      port_free[p] = !vout_q[p] || rdy[p];
      for (int unsigned c = 0; c < NP; c++) begin
        elig[p][c] = legal[c] && (tgt[c] == 2'(p)) && port_free[p] &&
                     ((lock_q[p] == OPEN) || (owner_q[p] == 2'(c)));
      end
    end
  end

`ifdef SA_ROUND_ROBIN_EN
  logic [1:0] ptr_q [NP];

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NP; p++) ptr_q[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (win_vld[p] && ((win_type[p] == FT_HEAD) || (win_type[p] == FT_SINGLE)))
          ptr_q[p] <= (win_id[p] == 2'd2) ? 2'd0 : win_id[p] + 2'd1;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) base[p] = ptr_q[p];
  end
`else
  always_comb begin
    for (int unsigned p = 0; p < NP; p++) base[p] = '0;
  end
`endif

  // With base fixed at E the search order degenerates to E > S > L.
  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      win_vld[p]  = 1'b0;
      win_id[p]   = '0;
      win_data[p] = '0;
      win_type[p] = FT_BODY;
      for (int unsigned k = 0; k < NP; k++) begin
        for (int unsigned c = 0; c < NP; c++) begin
          if (!win_vld[p] && elig[p][c] && (rr_dist(base[p], 2'(c)) == 2'(k))) begin
            win_vld[p]  = 1'b1;
            win_id[p]   = 2'(c);
            win_data[p] = din[c];
            win_type[p] = ftype_t'(din[c][DATASIZE-1 -: 2]);
          end
        end
      end
    end
  end

  always_comb begin
    gnt = illegal;
    for (int unsigned r = 0; r < NP; r++) begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (win_vld[p] && (win_id[p] == 2'(r))) gnt[r] = 1'b1;
      end
    end
    gnt = gnt & {NP{rst_n}};
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      lock_d[p]  = lock_q[p];
      owner_d[p] = owner_q[p];
      if (win_vld[p]) begin
        case (win_type[p])
          FT_HEAD: begin
            lock_d[p]  = LOCKED;
            owner_d[p] = win_id[p];
          end
          FT_TAIL: lock_d[p] = OPEN;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < NP; p++) begin
        dout_q[p]  <= '0;
        lock_q[p]  <= OPEN;
        owner_q[p] <= '0;
      end
      vout_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        lock_q[p]  <= lock_d[p];
        owner_q[p] <= owner_d[p];
        if (win_vld[p]) begin
          dout_q[p] <= win_data[p];
          vout_q[p] <= 1'b1;
        end else if (rdy[p]) begin
          vout_q[p] <= 1'b0;
        end
      end
      if (|illegal) err_q <= 1'b1;
    end
  end
endmodule
